seg_scroll_ctrl: RTL and testbench

Scrolling-message controller for the board's six 7-segment displays. It buffers a short message of 2-bit character codes loaded through a valid/ready port, then rotates the message across HEX5..HEX0 at a prescaled rate under start/stop/pause control. It sits between the switch/key front-end and the display pins, and owns the character-to-segment decode.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_char_decode.sv | 11 +
 rtl/seg_scroll_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_seg_scroll_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the scrolling 7-segment message controller.
package seg_pkg;

  // Controller states: idle/loading, scrolling, and frozen mid-scroll
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // 2-bit character codes
  localparam logic [1:0] CH_D     = 2'b00;
  localparam logic [1:0] CH_E     = 2'b01;
  localparam logic [1:0] CH_1     = 2'b10;
  localparam logic [1:0] CH_BLANK = 2'b11;

  // Active-low segment patterns, index 0 = top ... index 6 = middle
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_1     = 7'b1001111;

  // Map a character code onto its active-low segment pattern
  function automatic logic [0:6] code_to_seg(input logic [1:0] code);
    logic [0:6] seg;
    case (code)
      CH_D:    seg = SEG_D;
      CH_E:    seg = SEG_E;
      CH_1:    seg = SEG_1;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_char_decode.sv
// Character decoder: 2-bit code to active-low [0:6] segment pattern.
module seg_char_decode
  import seg_pkg::*;
(
  input  logic [1:0] i_code,
  output logic [0:6] o_seg
);

  assign o_seg = code_to_seg(i_code);

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scrolling-message controller: buffers a message of 2-bit character codes
// and rotates it (followed by one blank) across HEX5..HEX0.
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int MSG_DEPTH = 8,
  parameter int DIV       = 50_000_000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [1:0] load_code,
  input  logic       load_last,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  output logic       busy,
  output logic [0:6] HEX5,
  output logic [0:6] HEX4,
  output logic [0:6] HEX3,
  output logic [0:6] HEX2,
  output logic [0:6] HEX1,
  output logic [0:6] HEX0
);

  // Buffer index width, and stream pointer width (pointer reaches len, the trailing blank)
  localparam int IDX_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int PTR_W = $clog2(MSG_DEPTH + 1);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]       r_buf [MSG_DEPTH];
  logic [IDX_W-1:0] r_wr_cnt;
  logic [PTR_W-1:0] r_len;
  logic             r_msg_ok;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_win [6];

  logic             w_accept;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_wr_final;
  logic             w_go;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [PTR_W-1:0] w_idx [6];
  logic [1:0]       w_win_code [6];
  logic [0:6]       w_seg [6];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: stop dominates start and pause
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && r_msg_ok && !stop) w_state_next = ST_SCROLL;
      end
      ST_SCROLL: begin
        if (stop)       w_state_next = ST_IDLE;
        else if (pause) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop)        w_state_next = ST_IDLE;
        else if (!pause) w_state_next = ST_SCROLL;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    busy       = (r_state != ST_IDLE);
    load_ready = (r_state == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Message loading
  // ---------------------------------------------------------------------------

  assign w_accept   = load_valid && (r_state == ST_IDLE);
  // A beat arriving after a completed message restarts the buffer at index 0
  assign w_wr_idx   = r_msg_ok ? '0 : r_wr_cnt;
  assign w_wr_final = load_last || (w_wr_idx == IDX_W'(MSG_DEPTH - 1));

  // Write counter, message length and message-complete flag
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_wr_cnt <= '0;
      r_len    <= '0;
      r_msg_ok <= 1'b0;
    end else if (w_accept) begin
      if (w_wr_final) begin
        r_len    <= PTR_W'(w_wr_idx) + PTR_W'(1);
        r_msg_ok <= 1'b1;
        r_wr_cnt <= '0;
      end else begin
        r_msg_ok <= 1'b0;
        r_wr_cnt <= w_wr_idx + IDX_W'(1);
      end
    end
  end

  // Character buffer; contents are only meaningful while r_msg_ok is set
  always_ff @(posedge Clock) begin
    if (w_accept) begin
      r_buf[w_wr_idx] <= load_code;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and stream pointer
  // ---------------------------------------------------------------------------

  assign w_go      = (r_state == ST_IDLE) && (w_state_next == ST_SCROLL);
  // Stream length is len+1, so the pointer wraps after reaching len
  assign w_ptr_inc = (r_ptr == r_len) ? '0 : r_ptr + PTR_W'(1);

  // Prescaler counts only in SCROLL; both it and ptr freeze in HOLD
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_ptr   <= '0;
      r_presc <= '0;
    end else if (w_go) begin
      r_ptr   <= '0;
      r_presc <= '0;
    end else if (r_state == ST_SCROLL && !stop) begin
      if (r_presc == CNT_W'(DIV - 1)) begin
        r_presc <= '0;
        r_ptr   <= w_ptr_inc;
      end else begin
        r_presc <= r_presc + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display window
  // ---------------------------------------------------------------------------

  // Stream index per digit: HEX5 shows s[ptr], each digit to the right is one further on
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    v_idx = r_ptr;
    for (int k = 5; k >= 0; k--) begin
      w_idx[k] = v_idx;
      v_idx    = (v_idx == r_len) ? '0 : v_idx + PTR_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_win
      // Index len is the trailing blank of the circular stream
      assign w_win_code[gi] = (w_idx[gi] >= r_len) ? CH_BLANK
                                                   : r_buf[w_idx[gi][IDX_W-1:0]];
      seg_char_decode u_dec (
        .i_code (r_win[gi]),
        .o_seg  (w_seg[gi])
      );
    end
  endgenerate

  // Register the window codes; blank whenever the controller is idle
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int k = 0; k < 6; k++) r_win[k] <= CH_BLANK;
    end else begin
      for (int k = 0; k < 6; k++) begin
        r_win[k] <= (r_state == ST_IDLE) ? CH_BLANK : w_win_code[k];
      end
    end
  end

  assign HEX5 = w_seg[5];
  assign HEX4 = w_seg[4];
  assign HEX3 = w_seg[3];
  assign HEX2 = w_seg[2];
  assign HEX1 = w_seg[1];
  assign HEX0 = w_seg[0];

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Self-checking bench for seg_scroll_ctrl: a transaction-level reference model
// pushes the expected display/status into a queue every clock, and a monitor
// pops and compares against the DUT on the falling edge.
module tb_seg_scroll_ctrl;

  localparam int DEPTH = 8;
  localparam int DIVV  = 4;
  localparam logic [41:0] BLANK6 = {6{7'b1111111}};

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       load_valid = 1'b0;
  logic [1:0] load_code = 2'b00;
  logic       load_last = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       load_ready;
  logic       busy;
  logic [0:6] HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

  always #5 Clock = ~Clock;

  seg_scroll_ctrl #(.MSG_DEPTH(DEPTH), .DIV(DIVV)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_code  (load_code),
    .load_last  (load_last),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .busy       (busy),
    .HEX5       (HEX5),
    .HEX4       (HEX4),
    .HEX3       (HEX3),
    .HEX2       (HEX2),
    .HEX1       (HEX1),
    .HEX0       (HEX0)
  );

  typedef struct packed {
    logic [41:0] hex;
    logic        bsy;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: committed message, message in progress, run/hold flags,
  // position in the stream and cycles of scrolling since the last step
  int msg[$];
  int pend[$];
  bit m_ok   = 0;
  bit m_run  = 0;
  bit m_hold = 0;
  int m_pos  = 0;
  int m_phase = 0;

  function automatic logic [6:0] seg_of(input int c);
    logic [6:0] tab [4];
    tab[0] = 7'b1000010;  // d
    tab[1] = 7'b0110000;  // E
    tab[2] = 7'b1001111;  // 1
    tab[3] = 7'b1111111;  // blank
    return tab[c & 3];
  endfunction

  // Six-digit window {HEX5..HEX0} of the circular stream (message + one blank)
  function automatic logic [41:0] window_of();
    logic [41:0] w;
    int len;
    int idx;
    int c;
    len = msg.size() + 1;
    w = '0;
    for (int k = 0; k < 6; k++) begin
      idx = (m_pos + 5 - k) % len;
      c = (idx < msg.size()) ? msg[idx] : 3;
      w[k*7 +: 7] = seg_of(c);
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [43:0] got, input logic [43:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got hex=%h busy=%b rdy=%b want hex=%h busy=%b rdy=%b",
                  name, $time, got[43:2], got[1], got[0], want[43:2], want[1], want[0]);
  endtask

  // Reference model: evaluated at each rising edge from the inputs seen there
  initial begin : model
    exp_t e;
    bit   go;
    forever begin
      @(posedge Clock);
      if (!Resetn) begin
        msg.delete(); pend.delete();
        m_ok = 0; m_run = 0; m_hold = 0; m_pos = 0; m_phase = 0;
        e.hex = BLANK6;
      end else begin
        // Display reflects the situation before this edge
        e.hex = m_run ? window_of() : BLANK6;
        if (m_run) begin
          if (stop) m_run = 0;
          else if (m_hold) begin
            if (!pause) m_hold = 0;
          end else begin
            m_phase++;
            if (m_phase == DIVV) begin
              m_phase = 0;
              m_pos = (m_pos + 1) % (msg.size() + 1);
            end
            if (pause) m_hold = 1;
          end
        end else begin
          go = start && !stop && m_ok;
          if (load_valid) begin
            if (m_ok) pend.delete();
            pend.push_back(int'(load_code));
            if (load_last || pend.size() == DEPTH) begin
              msg = pend;
              pend.delete();
              m_ok = 1;
            end else begin
              m_ok = 0;
            end
          end
          if (go) begin
            m_run = 1; m_hold = 0; m_pos = 0; m_phase = 0;
          end
        end
      end
      e.bsy = m_run;
      e.rdy = !m_run;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare the DUT outputs against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, busy, load_ready},
              {e.hex, e.bsy, e.rdy});
      end
    end
  end

  // Advance n cycles; inputs change shortly after the falling edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge Clock);
      #1;
    end
  endtask

  task automatic load_one(input logic [1:0] code, input logic last);
    load_valid = 1'b1;
    load_code  = code;
    load_last  = last;
    cyc(1);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  initial begin : stim
    int n;
    bit uselast;
    Resetn = 1'b0;
    cyc(2);
    Resetn = 1'b1;
    cyc(2);

    // d,E,1 message; run through more than one full rotation
    load_one(2'b00, 1'b0);
    load_one(2'b01, 1'b0);
    load_one(2'b10, 1'b1);
    cyc(1);
    pulse_start();
    cyc(21);

    // Pause mid-count, hold 10 cycles, then resume
    cyc(2);
    pause = 1'b1;
    cyc(10);
    pause = 1'b0;
    cyc(12);

    // Asynchronous reset mid-scroll: outputs return immediately
    Resetn = 1'b0;
    #1;
    check("reset_hex",  {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, 2'b00}, {BLANK6, 2'b00});
    check("reset_busy", {43'd0, busy}, 44'd0);
    check("reset_rdy",  {43'd0, load_ready}, 44'd1);
    cyc(2);
    Resetn = 1'b1;
    cyc(1);
    pulse_start();   // no message after reset: ignored
    cyc(3);

    // Full-depth message without load_last; run past the 8 -> 0 wrap
    for (int i = 0; i < DEPTH; i++) load_one(2'($urandom_range(0, 3)), 1'b0);
    cyc(1);
    pulse_start();
    cyc(9 * DIVV + 6);
    pulse_stop();
    cyc(2);

    // Same-cycle start and stop in IDLE stays idle
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    cyc(3);
    pulse_start();
    cyc(10);
    pulse_stop();
    cyc(3);

    // Loads offered during SCROLL are refused; then a 2-character message
    pulse_start();
    load_valid = 1'b1;
    load_code  = 2'b01;
    cyc(8);
    load_valid = 1'b0;
    pulse_stop();
    cyc(1);
    load_one(2'b11, 1'b0);
    load_one(2'b00, 1'b1);
    cyc(1);
    pulse_start();
    cyc(14);
    pulse_stop();
    cyc(2);

    // Randomized messages with random pause toggling
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, DEPTH);
      uselast = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++)
        load_one(2'($urandom_range(0, 3)), (i == n - 1) ? uselast : 1'b0);
      cyc($urandom_range(0, 2));
      pulse_start();
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 7) == 0) pause = ~pause;
        cyc(1);
      end
      pause = 1'b0;
      pulse_stop();
      cyc(2);
    end

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
